// File: rtl/rs_stream_encoder.sv
// Systematic Reed-Solomon stream encoder: passes K_SYM message symbols through, then appends P_SYM parity.
// Optional RS_ENC_STATS_EN adds saturating cw_count / stall_count ports.
module rs_stream_encoder #(
  parameter int EGF_DIM = 4,
  parameter int ENC_SYM = 4,
  parameter int K_SYM   = 8,
  parameter int P_SYM   = 4,
  parameter logic [EGF_DIM:0] PRIM_POLY = 'h13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ENC_SYM*EGF_DIM-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ENC_SYM*EGF_DIM-1:0] out_data,
  output logic                       out_sop,
  output logic                       out_eop
`ifdef RS_ENC_STATS_EN
  ,
  output logic [15:0]                cw_count,
  output logic [15:0]                stall_count
`endif
);

  localparam int BW        = ENC_SYM * EGF_DIM;
  localparam int MSG_BEATS = K_SYM / ENC_SYM;
  localparam int PAR_BEATS = P_SYM / ENC_SYM;
  localparam int MAXB      = (MSG_BEATS > PAR_BEATS) ? MSG_BEATS : PAR_BEATS;
  localparam int CNT_W     = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef logic [EGF_DIM-1:0]             sym_t;
  typedef logic [P_SYM-1:0][EGF_DIM-1:0]  par_t;
  typedef enum logic {MSG, PAR} state_t;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t r;
    sym_t aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < EGF_DIM; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[EGF_DIM-1] ? ({aa[EGF_DIM-2:0], 1'b0} ^ PRIM_POLY[EGF_DIM-1:0])
                         : {aa[EGF_DIM-2:0], 1'b0};
    end
    return r;
  endfunction

  // Low-order coefficients of the monic g(x) = prod (x + alpha^i); index j holds the x^j term.
  function automatic par_t gen_poly();
    logic [P_SYM:0][EGF_DIM-1:0] g;
    sym_t root;
    g    = '0;
    g[0] = sym_t'(1);
    root = sym_t'(1);
    for (int i = 0; i < P_SYM; i++) begin
      for (int j = P_SYM; j > 0; j--) g[j] = g[j-1] ^ gf_mul(root, g[j]);
      g[0] = gf_mul(root, g[0]);
      root = gf_mul(root, sym_t'(2));
    end
    return g[P_SYM-1:0];
  endfunction

  localparam par_t GEN = gen_poly();

  function automatic par_t lfsr_step(par_t s, sym_t d);
    par_t n;
    sym_t fb;
    fb   = d ^ s[P_SYM-1];
    n[0] = gf_mul(fb, GEN[0]);
    for (int j = 1; j < P_SYM; j++) n[j] = s[j-1] ^ gf_mul(fb, GEN[j]);
    return n;
  endfunction

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  par_t             lfsr, absorb, par_shift;
  logic [BW-1:0]    par_top;
  logic             adv, in_fire, par_fire, msg_last, par_last;

  assign msg_last  = (cnt == CNT_W'(MSG_BEATS - 1));
  assign par_last  = (cnt == CNT_W'(PAR_BEATS - 1));
  assign par_top   = lfsr[P_SYM-1 -: ENC_SYM];
  assign par_shift = lfsr << BW;

  // ENC_SYM feedback steps unrolled, earliest (MS) symbol first.
  always_comb begin
    absorb = lfsr;
    for (int k = 0; k < ENC_SYM; k++)
      absorb = lfsr_step(absorb, in_data[(ENC_SYM-1-k)*EGF_DIM +: EGF_DIM]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MSG;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    in_fire  = 1'b0;
    par_fire = 1'b0;
    adv      = !out_valid || out_ready;
    case (state)
      MSG: begin
        in_ready = !rst && adv;
        in_fire  = in_valid && in_ready;
        if (in_fire && msg_last) state_d = PAR;
      end
      PAR: begin
        par_fire = adv;
        if (par_fire && par_last) state_d = MSG;
      end
      default: state_d = MSG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      lfsr      <= '0;
      cnt       <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_sop   <= (cnt == '0);
      out_eop   <= 1'b0;
      lfsr      <= absorb;
      cnt       <= msg_last ? '0 : cnt + 1'b1;
    end else if (par_fire) begin
      out_valid <= 1'b1;
      out_data  <= par_top;
      out_sop   <= 1'b0;
      out_eop   <= par_last;
      lfsr      <= par_last ? '0 : par_shift;
      cnt       <= par_last ? '0 : cnt + 1'b1;
    end else if (out_ready) begin
      // Beat drained with nothing new behind it.
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end
  end

`ifdef RS_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_count    <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid && out_ready && out_eop && cw_count != 16'hFFFF)
        cw_count <= cw_count + 16'd1;
      if (out_valid && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Bench for rs_stream_encoder: parity from polynomial long division over log/antilog GF(16) tables.
module tb_rs_stream_encoder;
  localparam int K = 8;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_sop, out_eop;
  logic [15:0] in_data, out_data;
`ifdef RS_ENC_STATS_EN
  logic [15:0] cw_count, stall_count;
`endif

  rs_stream_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop)
`ifdef RS_ENC_STATS_EN
    , .cw_count(cw_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [15:0] d; logic sop; logic eop; int t;} beat_t;
  beat_t obs[$];
  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      obs.push_back('{d: out_data, sop: out_sop, eop: out_eop, t: cyc});

  // GF(16) via exp/log tables and g(x) highest-degree first
  logic [3:0] gexp[0:14];
  int         glog[0:15];
  logic [3:0] gp[0:P];

  function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
    if (a == 0 || b == 0) return 4'd0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  task automatic init_model();
    logic [4:0] v;
    logic [3:0] t[0:P];
    v = 5'd1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v[3:0];
      glog[v[3:0]] = i;
      v = v << 1;
      if (v[4]) v = v ^ 5'h13;
    end
    for (int j = 0; j <= P; j++) gp[j] = 4'd0;
    gp[0] = 4'd1;
    for (int i = 0; i < P; i++) begin
      for (int j = 0; j <= P; j++) t[j] = 4'd0;
      for (int j = 0; j <= i; j++) begin
        t[j]   = t[j] ^ gp[j];
        t[j+1] = t[j+1] ^ gmul(gexp[i], gp[j]);
      end
      gp = t;
    end
  endtask

  function automatic logic [15:0] model_par(logic [31:0] msg);
    logic [3:0] r[0:K+P-1];
    logic [3:0] c;
    for (int i = 0; i < K; i++) r[i] = msg[(K-1-i)*4 +: 4];
    for (int i = K; i < K + P; i++) r[i] = 4'd0;
    for (int i = 0; i < K; i++) begin
      c = r[i];
      for (int j = 0; j <= P; j++) r[i+j] = r[i+j] ^ gmul(c, gp[j]);
    end
    return {r[K], r[K+1], r[K+2], r[K+3]};
  endfunction

  function automatic logic [3:0] syndrome(logic [47:0] cw, int i);
    logic [3:0] acc;
    acc = 4'd0;
    for (int s = 0; s < 12; s++) acc = gmul(acc, gexp[i]) ^ cw[(11-s)*4 +: 4];
    return acc;
  endfunction

  task automatic send_beat(input logic [15:0] d);
    int n;
    bit acc;
    n = 0; acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: beat %h not accepted, in_ready=%b required 1", d, in_ready);
    end
  endtask

  task automatic send_cw(input logic [31:0] msg);
    send_beat(msg[31:16]);
    send_beat(msg[15:0]);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic wait_obs(input int n);
    int c;
    c = 0;
    while (obs.size() < n && c < 100) begin @(posedge clk); #1; c++; end
    if (obs.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_obs: got %0d beats required %0d", obs.size(), n);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_hi: got %b required 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0000", out_data); end
    n_checks++;
    if ({out_sop, out_eop} !== 2'b00) begin n_fail++; $display("FAIL reset_sop_eop: got %b required 00", {out_sop, out_eop}); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_zero();
    logic [15:0] exp_d[3];
    obs.delete();
    @(posedge clk); #1;
    send_cw(32'h0);
    idle_in();
    wait_obs(3);
    exp_d = '{16'h0, 16'h0, model_par(32'h0)};
    n_checks++;
    if (obs.size() != 3) begin n_fail++; $display("FAIL zero_count: got %0d required 3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      n_checks++;
      if ({obs[i].d, obs[i].sop, obs[i].eop} !== {exp_d[i], i == 0, i == 2}) begin
        n_fail++;
        $display("FAIL zero_beat%0d: got %h sop=%b eop=%b required %h sop=%b eop=%b",
                 i, obs[i].d, obs[i].sop, obs[i].eop, exp_d[i], i == 0, i == 2);
      end
    end
  endtask

  task automatic test_known();
    logic [31:0] msg;
    logic [15:0] par;
    msg = 32'h0123_4567;
    par = model_par(msg);
    obs.delete();
    send_beat(msg[31:16]);
    send_beat(msg[15:0]);
    idle_in();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL known_in_ready_par: got %b required 0", in_ready); end
    wait_obs(3);
    n_checks++;
    if (obs.size() != 3) begin n_fail++; $display("FAIL known_count: got %0d required 3", obs.size()); end
    if (obs.size() == 3) begin
      n_checks++;
      if ({obs[0].d, obs[1].d} !== msg) begin n_fail++; $display("FAIL known_msg: got %h%h required %h", obs[0].d, obs[1].d, msg); end
      n_checks++;
      if (obs[2].d !== par) begin n_fail++; $display("FAIL known_parity: got %h required %h", obs[2].d, par); end
      n_checks++;
      if (obs[2].t - obs[1].t != 1 || obs[1].t - obs[0].t != 1) begin
        n_fail++; $display("FAIL known_gaps: got stamps %0d %0d %0d required consecutive", obs[0].t, obs[1].t, obs[2].t);
      end
      for (int i = 0; i < P; i++) begin
        n_checks++;
        if (syndrome({obs[0].d, obs[1].d, obs[2].d}, i) !== 4'd0) begin
          n_fail++; $display("FAIL known_syndrome%0d: got %h required 0", i, syndrome({obs[0].d, obs[1].d, obs[2].d}, i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] msgs[3];
    msgs = '{32'h0123_4567, 32'h89ab_cdef, 32'h0123_4567};
    obs.delete();
    for (int c = 0; c < 3; c++) send_cw(msgs[c]);
    idle_in();
    wait_obs(9);
    n_checks++;
    if (obs.size() != 9) begin n_fail++; $display("FAIL b2b_count: got %0d required 9", obs.size()); end
    if (obs.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        logic [15:0] e;
        e = (i % 3 == 0) ? msgs[i/3][31:16] : (i % 3 == 1) ? msgs[i/3][15:0] : model_par(msgs[i/3]);
        n_checks++;
        if ({obs[i].d, obs[i].sop, obs[i].eop} !== {e, i % 3 == 0, i % 3 == 2}) begin
          n_fail++; $display("FAIL b2b_beat%0d: got %h sop=%b eop=%b required %h", i, obs[i].d, obs[i].sop, obs[i].eop, e);
        end
      end
      n_checks++;
      if (obs[8].t - obs[0].t != 8) begin n_fail++; $display("FAIL b2b_span: got %0d cycles required 8", obs[8].t - obs[0].t); end
      n_checks++;
      if (obs[2].d !== obs[8].d) begin n_fail++; $display("FAIL b2b_same_parity: got %h vs %h required equal", obs[2].d, obs[8].d); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] m0, m1;
    logic [18:0] prev;
    bit          prev_stall;
    m0 = $urandom; m1 = $urandom;
    prev = '0; prev_stall = 0;
    obs.delete();
    fork
      begin send_cw(m0); send_cw(m1); idle_in(); end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (prev_stall) begin
            n_checks++;
            if ({out_valid, out_data, out_sop, out_eop} !== prev) begin
              n_fail++; $display("FAIL bp_stable: got %h required %h", {out_valid, out_data, out_sop, out_eop}, prev);
            end
          end
          prev_stall = out_valid && !out_ready;
          prev = {out_valid, out_data, out_sop, out_eop};
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_obs(6);
    n_checks++;
    if (obs.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d required 6", obs.size()); end
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      logic [31:0] m;
      logic [15:0] e;
      m = (i < 3) ? m0 : m1;
      e = (i % 3 == 0) ? m[31:16] : (i % 3 == 1) ? m[15:0] : model_par(m);
      n_checks++;
      if ({obs[i].d, obs[i].sop, obs[i].eop} !== {e, i % 3 == 0, i % 3 == 2}) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h required %h", i, obs[i].d, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] m;
    m = $urandom;
    out_ready = 1'b1;
    send_beat(16'hbeef);
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_sop, out_eop, in_ready} !== 4'b0000 || out_data !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_clear: got v=%b d=%h sop=%b eop=%b rdy=%b required all 0",
                         out_valid, out_data, out_sop, out_eop, in_ready);
    end
    rst = 1'b0;
    obs.delete();
    send_cw(m);
    idle_in();
    wait_obs(3);
    n_checks++;
    if (obs.size() != 3) begin n_fail++; $display("FAIL rstmid_count: got %0d required 3", obs.size()); end
    if (obs.size() == 3) begin
      n_checks++;
      if ({obs[0].d, obs[1].d, obs[2].d} !== {m, model_par(m)}) begin
        n_fail++; $display("FAIL rstmid_data: got %h%h%h required %h%h", obs[0].d, obs[1].d, obs[2].d, m, model_par(m));
      end
      n_checks++;
      if ({obs[0].sop, obs[1].sop, obs[2].sop, obs[2].eop} !== 4'b1001) begin
        n_fail++; $display("FAIL rstmid_flags: got %b required 1001", {obs[0].sop, obs[1].sop, obs[2].sop, obs[2].eop});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] msgs[20];
    bit done;
    done = 0;
    foreach (msgs[c]) msgs[c] = $urandom;
    obs.delete();
    fork
      begin
        for (int c = 0; c < 20; c++)
          for (int b = 0; b < 2; b++) begin
            int g;
            g = $urandom_range(0, 2);
            if (g > 0) begin idle_in(); repeat (g) begin @(posedge clk); #1; end end
            send_beat(b == 0 ? msgs[c][31:16] : msgs[c][15:0]);
          end
        idle_in();
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 3) != 0); end
        out_ready = 1'b1;
      end
    join
    wait_obs(60);
    n_checks++;
    if (obs.size() != 60) begin n_fail++; $display("FAIL rand_count: got %0d required 60", obs.size()); end
    for (int i = 0; i < 60 && i < obs.size(); i++) begin
      logic [15:0] e;
      e = (i % 3 == 0) ? msgs[i/3][31:16] : (i % 3 == 1) ? msgs[i/3][15:0] : model_par(msgs[i/3]);
      n_checks++;
      if ({obs[i].d, obs[i].sop, obs[i].eop} !== {e, i % 3 == 0, i % 3 == 2}) begin
        n_fail++; $display("FAIL rand_beat%0d: got %h sop=%b eop=%b required %h", i, obs[i].d, obs[i].sop, obs[i].eop, e);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    init_model();
    test_reset();
    test_zero();
    test_known();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
